// File: rtl/ysyx_25040129_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040129_axi_rr_arb
// Description : Round-robin AXI4 read arbiter for icache (0), PTW (1) and
//               LSU (2) onto one memory port. One read in flight at a time.
//               LSU write channel passes through. Outstanding writes are
//               counted so LSU reads wait until all writes have completed.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_axi_rr_arb #(
    parameter int WR_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    // requester read channels (index i at bits [i*W +: W])
    input  logic [95:0] m_araddr,
    input  logic [23:0] m_arlen,
    input  logic [5:0]  m_arburst,
    input  logic [8:0]  m_arsize,
    input  logic [2:0]  m_arvalid,
    output logic [2:0]  m_arready,
    output logic [95:0] m_rdata,
    output logic [5:0]  m_rresp,
    output logic [2:0]  m_rlast,
    output logic [2:0]  m_rvalid,
    input  logic [2:0]  m_rready,
    // memory-side read channel
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [1:0]  s_arburst,
    output logic [2:0]  s_arsize,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,
    // LSU write channel
    input  logic [31:0] lsu_awaddr,
    input  logic [2:0]  lsu_awsize,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    // memory-side write channel
    output logic [31:0] s_awaddr,
    output logic [2:0]  s_awsize,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready,
    // error report
    output logic        err_valid,
    output logic [1:0]  err_id
);

    localparam int              c_CNT_W  = $clog2(WR_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WR_MAX = c_CNT_W'(WR_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_grant;
    logic [1:0]          r_last;
    logic [c_CNT_W-1:0]  r_wr_cnt;
    logic                r_err_valid;
    logic [1:0]          r_err_id;

    logic [2:0]          w_elig;
    logic [1:0]          w_cand1;
    logic [1:0]          w_cand2;
    logic [1:0]          w_pick;
    logic                w_pick_valid;
    logic                w_aw_open;
    logic                w_aw_hs;
    logic                w_b_hs;
    logic                w_err_beat;
    int                  w_gi;

    // LSU reads are held off while any write is still outstanding
    assign w_elig       = m_arvalid & {(r_wr_cnt == '0), 2'b11};
    assign w_pick_valid = |w_elig;
    assign w_gi         = int'(r_grant);

    // Search order starts just after the last winner: last+1, last+2, last
    always_comb begin
        w_cand1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_cand2 = (r_last == 2'd0) ? 2'd2 : r_last - 2'd1;
        if (w_elig[w_cand1])
            w_pick = w_cand1;
        else if (w_elig[w_cand2])
            w_pick = w_cand2;
        else
            w_pick = r_last;
    end

    // Transaction FSM: arbitrate in IDLE, forward AR in ADDR, stream R in DATA
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 2'd0;
            r_last  <= 2'd2;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s_arvalid && s_arready)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (s_rvalid && s_rready && s_rlast)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-path steering: only the granted requester sees anything
    always_comb begin
        s_araddr  = '0;
        s_arlen   = '0;
        s_arburst = '0;
        s_arsize  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = '0;
        m_rvalid  = '0;
        if (r_state == S_ADDR) begin
            s_araddr         = m_araddr[w_gi*32 +: 32];
            s_arlen          = m_arlen[w_gi*8 +: 8];
            s_arburst        = m_arburst[w_gi*2 +: 2];
            s_arsize         = m_arsize[w_gi*3 +: 3];
            s_arvalid        = m_arvalid[r_grant];
            m_arready[r_grant] = s_arready;
        end else if (r_state == S_DATA) begin
            m_rdata[w_gi*32 +: 32] = s_rdata;
            m_rresp[w_gi*2 +: 2]   = s_rresp;
            m_rlast[r_grant]       = s_rlast;
            m_rvalid[r_grant]      = s_rvalid;
            s_rready               = m_rready[r_grant];
        end
    end

    // Write pass-through with AW throttled at the outstanding limit
    assign w_aw_open   = (r_wr_cnt != c_WR_MAX);
    assign lsu_awready = s_awready & w_aw_open;
    assign s_awvalid   = lsu_awvalid & w_aw_open;
    assign s_awaddr    = lsu_awaddr;
    assign s_awsize    = lsu_awsize;
    assign s_wdata     = lsu_wdata;
    assign s_wstrb     = lsu_wstrb;
    assign s_wvalid    = lsu_wvalid;
    assign lsu_wready  = s_wready;
    assign lsu_bresp   = s_bresp;
    assign lsu_bvalid  = s_bvalid;
    assign s_bready    = lsu_bready;

    assign w_aw_hs = s_awvalid & s_awready;
    assign w_b_hs  = s_bvalid & lsu_bready;

    // Outstanding-write counter: AW increments, B decrements, both cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
                2'b01:   r_wr_cnt <= (r_wr_cnt != '0) ? r_wr_cnt - 1'b1 : r_wr_cnt;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    assign w_err_beat = (r_state == S_DATA) & s_rvalid & s_rready & s_rresp[1];

    // One-cycle error pulse tagged with the requester that got the bad beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_id    <= 2'd0;
        end else begin
            r_err_valid <= w_err_beat;
            if (w_err_beat)
                r_err_id <= r_grant;
        end
    end

    assign err_valid = r_err_valid;
    assign err_id    = r_err_id;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_axi_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040129_axi_rr_arb
// Description : Directed self-checking bench for the round-robin read arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040129_axi_rr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] m_araddr;
    logic [23:0] m_arlen;
    logic [5:0]  m_arburst;
    logic [8:0]  m_arsize;
    logic [2:0]  m_arvalid, m_arready;
    logic [95:0] m_rdata;
    logic [5:0]  m_rresp;
    logic [2:0]  m_rlast, m_rvalid, m_rready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [1:0]  s_arburst;
    logic [2:0]  s_arsize;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid, s_rready;
    logic [31:0] lsu_awaddr, lsu_wdata, s_awaddr, s_wdata;
    logic [2:0]  lsu_awsize, s_awsize;
    logic [3:0]  lsu_wstrb, s_wstrb;
    logic [1:0]  lsu_bresp, s_bresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic        lsu_bvalid, lsu_bready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        err_valid;
    logic [1:0]  err_id;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_25040129_axi_rr_arb #(.WR_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arsize(s_arsize), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awvalid(lsu_awvalid),
        .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .err_valid(err_valid), .err_id(err_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory-side responder for one read: accepts the AR, returns beats
    // base, base+1, ... and reports which requester saw the traffic.
    task automatic slave_txn(input int beats, input logic [31:0] base,
                             input logic [1:0] resp, output int gnt,
                             output int wait_cyc, output logic [31:0] addr,
                             output bit ok);
        logic [95:0] ed;
        logic [5:0]  er;
        logic [2:0]  oh;
        gnt = -1; wait_cyc = 0; addr = '0; ok = 1'b1;
        s_arready = 1'b1;
        #1;
        while (!s_arvalid && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        if (!s_arvalid) begin
            s_arready = 1'b0;
            return;
        end
        addr = s_araddr;
        for (int i = 0; i < 3; i++)
            if (m_arready[i]) gnt = i;
        if ($countones(m_arready) != 1) ok = 1'b0;
        tick();
        s_arready = 1'b0;
        m_arvalid[gnt] = 1'b0;
        oh = 3'b001 << gnt;
        for (int k = 0; k < beats; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = base + 32'(k);
            s_rresp  = resp;
            s_rlast  = (k == beats - 1);
            #1;
            ed = '0; ed[gnt*32 +: 32] = base + 32'(k);
            er = '0; er[gnt*2 +: 2] = resp;
            if (m_rvalid !== oh || m_rdata !== ed || m_rresp !== er ||
                m_rlast !== ((k == beats - 1) ? oh : 3'b000) || s_rready !== 1'b1)
                ok = 1'b0;
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({s_arvalid, s_rready, m_arready, m_rvalid, err_valid} !== 9'd0)
            $display("FAIL reset_handshakes: got %b required 0",
                     {s_arvalid, s_rready, m_arready, m_rvalid, err_valid});
        else n_pass++;
        n_total++;
        if (dut.r_wr_cnt !== 2'd0 || m_rdata !== 96'd0 || s_araddr !== 32'd0)
            $display("FAIL reset_state: wr_cnt %0d rdata %h araddr %h required 0",
                     dut.r_wr_cnt, m_rdata, s_araddr);
        else n_pass++;
    endtask

    task automatic test_single_burst();
        logic [95:0] ed;
        m_arvalid = 3'b001;
        #1;
        n_total++;
        if (s_arvalid !== 1'b0 || m_arready !== 3'b000)
            $display("FAIL idle_no_comb_path: s_arvalid %b m_arready %b required 0 000",
                     s_arvalid, m_arready);
        else n_pass++;
        tick();
        s_arready = 1'b1;
        #1;
        n_total++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || s_arlen !== 8'd3 ||
            s_arburst !== 2'b01 || m_arready !== 3'b001)
            $display("FAIL burst_ar: valid %b addr %h len %0d burst %b ready %b required 1 80000000 3 01 001",
                     s_arvalid, s_araddr, s_arlen, s_arburst, m_arready);
        else n_pass++;
        tick();
        s_arready = 1'b0;
        m_arvalid = 3'b000;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'h11 * 32'(k + 1);
            s_rlast  = (k == 3);
            #1;
            ed = {64'd0, 32'h11 * 32'(k + 1)};
            n_total++;
            if (m_rvalid !== 3'b001 || m_rdata !== ed || m_rlast !== ((k == 3) ? 3'b001 : 3'b000))
                $display("FAIL burst_beat%0d: rvalid %b rdata %h rlast %b required 001 %h",
                         k, m_rvalid, m_rdata, m_rlast, ed);
            else n_pass++;
            tick();
        end
        s_rvalid = 1'b1; s_rlast = 1'b0;
        #1;
        n_total++;
        if (m_rvalid !== 3'b000 || s_rready !== 1'b0 || s_arvalid !== 1'b0)
            $display("FAIL burst_back_to_idle: rvalid %b rready %b arvalid %b required 000 0 0",
                     m_rvalid, s_rready, s_arvalid);
        else n_pass++;
        s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic test_round_robin();
        int g, w; logic [31:0] a; bit ok;
        int exp_g[4] = '{0, 1, 2, 0};
        do_reset();
        m_arvalid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_arvalid = 3'b011;
            slave_txn(1, 32'h100 * 32'(i + 1), 2'b00, g, w, a, ok);
            n_total++;
            if (g !== exp_g[i] || !ok || a !== m_araddr[exp_g[i]*32 +: 32])
                $display("FAIL rr_grant%0d: grant %0d ok %0d addr %h required %0d 1",
                         i, g, ok, a, exp_g[i]);
            else n_pass++;
            n_total++;
            if (w !== 1)
                $display("FAIL back_to_back%0d: idle cycles %0d required 1", i, w);
            else n_pass++;
        end
        m_arvalid = 3'b000;
        tick();
    endtask

    task automatic test_write_order();
        int g, w; logic [31:0] a; bit ok;
        lsu_awaddr = 32'h8000_1000; lsu_awvalid = 1'b1; s_awready = 1'b1;
        #1;
        n_total++;
        if (lsu_awready !== 1'b1 || s_awvalid !== 1'b1 || s_awaddr !== 32'h8000_1000)
            $display("FAIL aw_pass: awready %b s_awvalid %b s_awaddr %h required 1 1 80001000",
                     lsu_awready, s_awvalid, s_awaddr);
        else n_pass++;
        tick();
        lsu_awvalid = 1'b0;
        m_arvalid = 3'b110;
        slave_txn(1, 32'hBEEF, 2'b00, g, w, a, ok);
        n_total++;
        if (g !== 1 || !ok)
            $display("FAIL ptw_before_lsu: grant %0d ok %0d required 1 1", g, ok);
        else n_pass++;
        tick();
        n_total++;
        if (s_arvalid !== 1'b0)
            $display("FAIL lsu_held_off: s_arvalid %b required 0", s_arvalid);
        else n_pass++;
        s_bvalid = 1'b1; lsu_bready = 1'b1;
        #1;
        n_total++;
        if (lsu_bvalid !== 1'b1 || s_bready !== 1'b1 || s_arvalid !== 1'b0)
            $display("FAIL b_cycle: bvalid %b bready %b arvalid %b required 1 1 0",
                     lsu_bvalid, s_bready, s_arvalid);
        else n_pass++;
        tick();
        s_bvalid = 1'b0; lsu_bready = 1'b0;
        slave_txn(1, 32'hCAFE, 2'b00, g, w, a, ok);
        n_total++;
        if (g !== 2 || !ok || w !== 1 || a !== 32'hA200_0000)
            $display("FAIL lsu_after_b: grant %0d ok %0d wait %0d addr %h required 2 1 1 a2000000",
                     g, ok, w, a);
        else n_pass++;
    endtask

    task automatic test_write_limit();
        lsu_awvalid = 1'b1; s_awready = 1'b1;
        tick(); tick(); tick();
        n_total++;
        if (dut.r_wr_cnt !== 2'd3 || lsu_awready !== 1'b0 || s_awvalid !== 1'b0)
            $display("FAIL wr_full: cnt %0d awready %b s_awvalid %b required 3 0 0",
                     dut.r_wr_cnt, lsu_awready, s_awvalid);
        else n_pass++;
        s_bvalid = 1'b1; lsu_bready = 1'b1;
        tick();
        s_bvalid = 1'b0;
        n_total++;
        if (dut.r_wr_cnt !== 2'd2 || lsu_awready !== 1'b1)
            $display("FAIL wr_after_b: cnt %0d awready %b required 2 1", dut.r_wr_cnt, lsu_awready);
        else n_pass++;
        tick();
        n_total++;
        if (dut.r_wr_cnt !== 2'd3)
            $display("FAIL wr_4th_aw: cnt %0d required 3", dut.r_wr_cnt);
        else n_pass++;
        lsu_awvalid = 1'b0; s_bvalid = 1'b1;
        tick();
        lsu_awvalid = 1'b1;
        tick();
        n_total++;
        if (dut.r_wr_cnt !== 2'd2)
            $display("FAIL wr_aw_and_b: cnt %0d required 2", dut.r_wr_cnt);
        else n_pass++;
        lsu_awvalid = 1'b0;
        tick(); tick();
        s_bvalid = 1'b0; lsu_bready = 1'b0;
        n_total++;
        if (dut.r_wr_cnt !== 2'd0)
            $display("FAIL wr_drain: cnt %0d required 0", dut.r_wr_cnt);
        else n_pass++;
    endtask

    task automatic test_error();
        int g, w; logic [31:0] a; bit ok;
        m_arvalid = 3'b010;
        slave_txn(1, 32'hDEAD, 2'b10, g, w, a, ok);
        n_total++;
        if (g !== 1 || !ok || err_valid !== 1'b1 || err_id !== 2'd1)
            $display("FAIL err_pulse: grant %0d ok %0d err_valid %b err_id %0d required 1 1 1 1",
                     g, ok, err_valid, err_id);
        else n_pass++;
        tick();
        n_total++;
        if (err_valid !== 1'b0)
            $display("FAIL err_one_cycle: err_valid %b required 0", err_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g, w; logic [31:0] a; bit ok;
        lsu_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        lsu_awvalid = 1'b0;
        m_arvalid = 3'b001;
        tick();
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0; m_arvalid = 3'b000;
        s_rvalid = 1'b1; s_rdata = 32'h55; s_rlast = 1'b0;
        #1;
        n_total++;
        if (m_rvalid !== 3'b001)
            $display("FAIL mid_data: rvalid %b required 001", m_rvalid);
        else n_pass++;
        rst = 1'b1; m_arvalid = 3'b111;
        tick();
        n_total++;
        if ({m_rvalid, m_arready, s_rready, s_arvalid, err_valid} !== 9'd0 ||
            m_rdata !== 96'd0 || dut.r_wr_cnt !== 2'd0)
            $display("FAIL mid_reset: outs %b rdata %h cnt %0d required 0",
                     {m_rvalid, m_arready, s_rready, s_arvalid, err_valid}, m_rdata, dut.r_wr_cnt);
        else n_pass++;
        rst = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        slave_txn(1, 32'h77, 2'b00, g, w, a, ok);
        n_total++;
        if (g !== 0 || !ok || w !== 1)
            $display("FAIL post_reset_grant: grant %0d ok %0d wait %0d required 0 1 1", g, ok, w);
        else n_pass++;
        m_arvalid = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_araddr  = {32'hA200_0000, 32'hA100_0000, 32'h8000_0000};
        m_arlen   = {8'd0, 8'd0, 8'd3};
        m_arburst = {2'b01, 2'b01, 2'b01};
        m_arsize  = {3'd2, 3'd2, 3'd2};
        m_arvalid = '0; m_rready = 3'b111;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        lsu_awaddr = '0; lsu_awsize = 3'd2; lsu_awvalid = 1'b0;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_write_order();
        test_write_limit();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
